nqueens_collector: RTL and testbench
====================================

NQUEENS_COLLECTOR -- requirements
Module: nqueens_collector

Interface
REQ-001 SHALL have parameter IDWIDTH, default 4, width of one column value.
REQ-002 SHALL have parameter NROWS, default 8, board rows (nodes in the scan ring).
REQ-003 SHALL have parameter DEPTH, default 16, solution FIFO entries (power of two).
REQ-004 Clk  input  1  single clock; all state on posedge Clk.
REQ-005 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 RD, WR  input  1 each  global bus read and write strobes.
REQ-007 Addr  input  GlobalAddrWidth  bus address; low IDWIDTH bits decoded.
REQ-008 DataIn  input  GlobalDataWidth  bus write data (unused except as a strobe qualifier).
REQ-009 DataOut  output  GlobalDataWidth  register read data; GlobalDataHighZ when not addressed.
REQ-010 Id  input  IDWIDTH  base address of this block.
REQ-011 SolveIn  input  1  one-cycle pulse from last-row node CallOut: full placement found.
REQ-012 ExhaustIn  input  1  one-cycle pulse from first-row node ReturnOut: search space exhausted.
REQ-013 ScanIn  input  IDWIDTH  column value at the scan-ring tail.
REQ-014 ScanOut  output  IDWIDTH  value fed back to the scan-ring head.
REQ-015 ScanEnable  output  1  shifts the node scan ring one position.
REQ-016 ResumeOut  output  1  one-cycle pulse into last-row ReturnIn to continue the search.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, SHIFT, PUSH, RESUME, DONE.
REQ-018 IDLE->WAIT on bus write to Id+0; the same write clears count, FIFO, and flags.
REQ-019 WAIT->SHIFT on SolveIn; WAIT->DONE on ExhaustIn; ExhaustIn has priority when both are asserted.
REQ-020 SHIFT SHALL assert ScanEnable for exactly NROWS consecutive cycles, sampling ScanIn each cycle into a shift register.
REQ-021 The k-th sample (k=0 first) SHALL occupy solution bits [IDWIDTH*k +: IDWIDTH]; NROWS*IDWIDTH <= GlobalDataWidth.
REQ-022 ScanOut SHALL equal ScanIn combinationally while ScanEnable is asserted, and 0 otherwise, so the ring is restored after NROWS shifts.
REQ-023 PUSH SHALL increment the 16-bit solution count, saturating at 0xFFFF, and write the packed word into the FIFO.
REQ-024 RESUME SHALL assert ResumeOut for one cycle, then go to WAIT; SolveIn arriving during SHIFT/PUSH/RESUME is ignored.
REQ-025 DONE SHALL hold until the next write to Id+0 (->WAIT after clear).
REQ-026 Read Id+0 SHALL return the count; read Id+1 SHALL return the FIFO head and pop one entry on that RD cycle; a pop when empty returns 0 with no pointer change.
REQ-027 Read Id+2 SHALL return {overflow, done, full, empty} in bits [3:0].
REQ-028 A simultaneous push and pop SHALL leave occupancy unchanged, with both taking effect.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; full = DEPTH entries, empty = 0 entries.

Reset
REQ-030 On Reset=0, the block SHALL go to IDLE immediately; count=0, FIFO empty, overflow=0, done=0, ScanEnable=0, ResumeOut=0, ScanOut=0.
REQ-031 Reset asserted mid-SHIFT SHALL abandon the partial capture; no push occurs.

Configuration
REQ-032 Macro NQUEENS_COLLECT_STALL_EN defined: PUSH with a full FIFO SHALL wait in PUSH until a pop frees space, then push; overflow never sets.
REQ-033 Macro undefined: PUSH with a full FIFO SHALL drop the word, set sticky overflow, still increment the count, and proceed to RESUME.

Verification
REQ-034 Clear, then SolveIn with the ring holding 0,4,7,5,2,6,1,3 (tail first) -> 8 ScanEnable cycles, FIFO word 0x3162_5740, count=1, one ResumeOut pulse, ring contents unchanged.
REQ-035 SolveIn and ExhaustIn asserted in the same WAIT cycle -> DONE, count unchanged, no ScanEnable.
REQ-036 17 solutions with no pops, macro undefined -> full=1, overflow=1, count=17, the first 16 words are retained.
REQ-037 Same stimulus, macro defined -> FSM stalls in PUSH; one pop of Id+1 -> 17th word pushed, then ResumeOut.
REQ-038 Reset=0 at the 3rd SHIFT cycle -> IDLE, FIFO empty, count=0, ScanEnable low asynchronously.
REQ-039 Pop of Id+1 in the same cycle as PUSH with 5 entries -> occupancy remains 5 and correct FIFO order is preserved.

Source files
------------

// File: rtl/nqueens_collector_if.sv
// Global register bus as seen by one collector block: strobes, address and data.
interface nqueens_collector_if #(
    parameter int GlobalAddrWidth = 16,
    parameter int GlobalDataWidth = 32
);
    logic                       RD;
    logic                       WR;
    logic [GlobalAddrWidth-1:0] Addr;
    logic [GlobalDataWidth-1:0] DataIn;
    logic [GlobalDataWidth-1:0] DataOut;

    modport master (output RD, WR, Addr, DataIn, input DataOut);
    modport slave  (input RD, WR, Addr, DataIn, output DataOut);
endinterface

// File: rtl/nqueens_collector.sv
// Captures each full N-queens placement from the node scan ring into a bus-readable FIFO.
// Define NQUEENS_COLLECT_STALL_EN to stall on a full FIFO instead of dropping with sticky overflow.
module nqueens_collector #(
    parameter int IDWIDTH         = 4,
    parameter int NROWS           = 8,
    parameter int DEPTH           = 16,
    parameter int GlobalAddrWidth = 16,
    parameter int GlobalDataWidth = 32,
    // Idle bus value when this block is not addressed; 'z on a true tristate fabric.
    parameter logic [GlobalDataWidth-1:0] GlobalDataHighZ = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    nqueens_collector_if.slave Bus,
    input  logic [IDWIDTH-1:0] Id,
    input  logic               SolveIn,
    input  logic               ExhaustIn,
    input  logic [IDWIDTH-1:0] ScanIn,
    output logic [IDWIDTH-1:0] ScanOut,
    output logic               ScanEnable,
    output logic               ResumeOut
);
    localparam int SolWidth = NROWS * IDWIDTH;
    localparam int PtrWidth = $clog2(DEPTH);
    localparam int CntWidth = $clog2(NROWS) + 1;

    typedef enum logic [2:0] {IDLE, WAIT, SHIFT, PUSH, RESUME, DONE} stateT;

    stateT               state;
    logic [15:0]         solCount;
    logic                overflow;
    logic                done;
    logic [CntWidth-1:0] shiftCnt;
    logic [SolWidth-1:0] capture;
    logic [SolWidth-1:0] mem [DEPTH];
    logic [PtrWidth-1:0] wrPtr;
    logic [PtrWidth-1:0] rdPtr;
    logic [PtrWidth:0]   occ;
    logic                full;
    logic                empty;
    logic                clearWr;
    logic                popRd;
    logic                canPush;
    logic                doPush;
    logic [IDWIDTH-1:0]  offset;
    logic                unusedBits;

    // Only the low IDWIDTH address bits take part in decode, so Id+n wraps.
    assign offset     = Bus.Addr[IDWIDTH-1:0] - Id;
    assign full       = occ == (PtrWidth+1)'(DEPTH);
    assign empty      = occ == '0;
    assign clearWr    = Bus.WR && offset == IDWIDTH'(0);
    assign popRd      = Bus.RD && offset == IDWIDTH'(1) && !empty;
    assign canPush    = !full || popRd;
    assign doPush     = state == PUSH && canPush && !clearWr;
    assign unusedBits = ^{Bus.DataIn, Bus.Addr[GlobalAddrWidth-1:IDWIDTH]};
    assign ScanOut    = ScanEnable ? ScanIn : '0;

    always_comb begin
        Bus.DataOut = GlobalDataHighZ;
        if (Bus.RD) begin
            if (offset == IDWIDTH'(0))
                Bus.DataOut = GlobalDataWidth'(solCount);
            else if (offset == IDWIDTH'(1))
                Bus.DataOut = empty ? '0 : GlobalDataWidth'(mem[rdPtr]);
            else if (offset == IDWIDTH'(2))
                Bus.DataOut = GlobalDataWidth'({overflow, done, full, empty});
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush) mem[wrPtr] <= capture;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            solCount   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            ScanEnable <= 1'b0;
            ResumeOut  <= 1'b0;
            shiftCnt   <= '0;
            capture    <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            occ        <= '0;
        end else if (clearWr) begin
            state      <= WAIT;
            solCount   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            ScanEnable <= 1'b0;
            ResumeOut  <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            occ        <= '0;
        end else begin
            ResumeOut <= 1'b0;
            if (popRd)  rdPtr <= rdPtr + 1'b1;
            if (doPush) wrPtr <= wrPtr + 1'b1;
            occ <= occ + (PtrWidth+1)'(doPush) - (PtrWidth+1)'(popRd);
            case (state)
                WAIT: begin
                    if (ExhaustIn) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (SolveIn) begin
                        state      <= SHIFT;
                        ScanEnable <= 1'b1;
                        shiftCnt   <= '0;
                    end
                end
                SHIFT: begin
                    // First sample ends up in the lowest IDWIDTH bits after NROWS shifts.
                    capture  <= {ScanIn, capture[SolWidth-1:IDWIDTH]};
                    shiftCnt <= shiftCnt + 1'b1;
                    if (shiftCnt == CntWidth'(NROWS - 1)) begin
                        ScanEnable <= 1'b0;
                        state      <= PUSH;
                    end
                end
                PUSH: begin
`ifdef NQUEENS_COLLECT_STALL_EN
                    if (canPush) begin
                        solCount  <= (solCount == 16'hFFFF) ? solCount : solCount + 16'd1;
                        ResumeOut <= 1'b1;
                        state     <= RESUME;
                    end
`else
                    solCount  <= (solCount == 16'hFFFF) ? solCount : solCount + 16'd1;
                    if (!canPush) overflow <= 1'b1;
                    ResumeOut <= 1'b1;
                    state     <= RESUME;
`endif
                end
                RESUME:  state <= WAIT;
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_nqueens_collector.sv
// Randomized bench for nqueens_collector: emulates the node scan ring and models the FIFO with a queue.
module tb_nqueens_collector;
    localparam int IDW = 4;
    localparam int NR  = 8;
    localparam int DEP = 16;
    localparam int AW  = 16;
    localparam int DW  = 32;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [IDW-1:0] Id = 4'hA;
    logic           SolveIn = 1'b0;
    logic           ExhaustIn = 1'b0;
    logic [IDW-1:0] ScanIn;
    logic [IDW-1:0] ScanOut;
    logic           ScanEnable;
    logic           ResumeOut;
    logic [IDW-1:0] ring [NR];

    int tests = 0;
    int fails = 0;
    int seSeen = 0;
    int rsSeen = 0;
    int scanBad = 0;

    logic [DW-1:0] modelQ [$];
    int            modelCount;
    bit            modelOvf;
    bit            modelDone;

    nqueens_collector_if #(.GlobalAddrWidth(AW), .GlobalDataWidth(DW)) bus ();

    nqueens_collector #(
        .IDWIDTH(IDW), .NROWS(NR), .DEPTH(DEP),
        .GlobalAddrWidth(AW), .GlobalDataWidth(DW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Bus(bus), .Id(Id),
        .SolveIn(SolveIn), .ExhaustIn(ExhaustIn),
        .ScanIn(ScanIn), .ScanOut(ScanOut),
        .ScanEnable(ScanEnable), .ResumeOut(ResumeOut)
    );

    always #5 Clk = ~Clk;

    // Ring of row nodes: tail feeds ScanIn, head takes ScanOut on every enabled edge.
    assign ScanIn = ring[0];
    always @(posedge Clk) begin
        if (ScanEnable) begin
            for (int i = 0; i < NR - 1; i++) ring[i] <= ring[i+1];
            ring[NR-1] <= ScanOut;
        end
    end

    function automatic logic [DW-1:0] ringWord();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < NR; k++) w = w | (DW'(ring[k]) << (IDW * k));
        return w;
    endfunction

    function automatic logic [DW-1:0] expStatus();
        return DW'({modelOvf, modelDone, modelQ.size() == DEP, modelQ.size() == 0});
    endfunction

    task automatic modelSolve(input logic [DW-1:0] w);
        if (modelCount < 65535) modelCount++;
        if (modelQ.size() < DEP) modelQ.push_back(w);
        else modelOvf = 1'b1;
    endtask

    task automatic sampleCycle();
        if (ScanEnable === 1'b1) begin
            seSeen++;
            if (ScanOut !== ScanIn) scanBad++;
        end else if (ScanOut !== '0) scanBad++;
        if (ResumeOut === 1'b1) rsSeen++;
    endtask

    task automatic waitCycles(input int n);
        sampleCycle();
        repeat (n - 1) begin
            @(negedge Clk);
            sampleCycle();
        end
    endtask

    task automatic setAddr(input int off);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[IDW-1:0] = Id + IDW'(off);
        bus.Addr = a;
    endtask

    task automatic busWrite(input int off);
        @(negedge Clk);
        setAddr(off);
        bus.DataIn = $urandom;
        bus.WR = 1'b1;
        @(negedge Clk);
        bus.WR = 1'b0;
    endtask

    task automatic busRead(input int off, output logic [DW-1:0] d);
        @(negedge Clk);
        setAddr(off);
        bus.RD = 1'b1;
        #1 d = bus.DataOut;
        @(negedge Clk);
        bus.RD = 1'b0;
    endtask

    task automatic clearAll();
        busWrite(0);
        modelQ.delete();
        modelCount = 0;
        modelOvf = 1'b0;
        modelDone = 1'b0;
    endtask

    task automatic randomRing();
        for (int i = 0; i < NR; i++) ring[i] <= IDW'($urandom_range(0, 15));
        @(negedge Clk);
    endtask

    task automatic doSolve();
        @(negedge Clk);
        SolveIn = 1'b1;
        @(negedge Clk);
        SolveIn = 1'b0;
        waitCycles(14);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        int se0;
        Reset = 1'b0;
        bus.RD = 1'b0; bus.WR = 1'b0; bus.Addr = '0; bus.DataIn = '0;
        for (int i = 0; i < NR; i++) ring[i] <= '0;
        repeat (2) @(negedge Clk);
        tests++;
        if ({ScanEnable, ResumeOut, ScanOut} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ScanEnable=%b ResumeOut=%b ScanOut=%h, want all 0", ScanEnable, ResumeOut, ScanOut);
        end
        Reset = 1'b1;
        tests++;
        if (bus.DataOut !== '0) begin
            fails++;
            $display("FAIL idle_bus: DataOut=%h want 0", bus.DataOut);
        end
        busRead(0, d);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL reset_count: got %h want 0", d); end
        busRead(2, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL reset_status: got %h want 1", d); end
        busRead(5, d);
        tests++;
        if (d !== '0) begin fails++; $display("FAIL unmapped_read: got %h want 0", d); end
        se0 = seSeen;
        doSolve();
        tests++;
        if (seSeen != se0) begin fails++; $display("FAIL idle_ignores_solve: %0d shifts want 0", seSeen - se0); end
    endtask

    task automatic test_solution();
        logic [DW-1:0] d;
        int se0, rs0, bad0;
        clearAll();
        ring <= '{4'd0, 4'd4, 4'd7, 4'd5, 4'd2, 4'd6, 4'd1, 4'd3};
        @(negedge Clk);
        se0 = seSeen; rs0 = rsSeen; bad0 = scanBad;
        doSolve();
        tests++;
        if (seSeen - se0 != NR) begin fails++; $display("FAIL solve_shifts: got %0d want %0d", seSeen - se0, NR); end
        tests++;
        if (rsSeen - rs0 != 1) begin fails++; $display("FAIL solve_resume: got %0d want 1", rsSeen - rs0); end
        tests++;
        if (scanBad != bad0) begin fails++; $display("FAIL scanout_follow: %0d bad cycles want 0", scanBad - bad0); end
        tests++;
        if (ringWord() !== 32'h3162_5740) begin fails++; $display("FAIL ring_restored: got %h want 31625740", ringWord()); end
        busRead(0, d);
        tests++;
        if (d !== 32'd1) begin fails++; $display("FAIL solve_count: got %h want 1", d); end
        busRead(1, d);
        tests++;
        if (d !== 32'h3162_5740) begin fails++; $display("FAIL solve_word: got %h want 31625740", d); end
        busRead(1, d);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL empty_pop: got %h want 0", d); end
        busRead(2, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL solve_status: got %h want 1", d); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d, w;
        int n, bad0;
        clearAll();
        bad0 = scanBad;
        n = $urandom_range(4, 8);
        for (int s = 0; s < n; s++) begin
            randomRing();
            w = ringWord();
            doSolve();
            modelSolve(w);
            if ($urandom_range(0, 2) == 0) begin
                busRead(1, d);
                w = modelQ.pop_front();
                tests++;
                if (d !== w) begin fails++; $display("FAIL rand_pop: got %h want %h", d, w); end
            end
        end
        tests++;
        if (scanBad != bad0) begin fails++; $display("FAIL rand_scanout: %0d bad cycles want 0", scanBad - bad0); end
        busRead(0, d);
        tests++;
        if (d !== DW'(modelCount)) begin fails++; $display("FAIL rand_count: got %h want %h", d, modelCount); end
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL rand_status: got %h want %h", d, expStatus()); end
        while (modelQ.size() > 0) begin
            busRead(1, d);
            w = modelQ.pop_front();
            tests++;
            if (d !== w) begin fails++; $display("FAIL rand_drain: got %h want %h", d, w); end
        end
    endtask

    task automatic test_exhaust_priority();
        logic [DW-1:0] d;
        int se0, rs0;
        clearAll();
        randomRing();
        d = ringWord();
        doSolve();
        modelSolve(d);
        se0 = seSeen;
        @(negedge Clk);
        SolveIn = 1'b1; ExhaustIn = 1'b1;
        @(negedge Clk);
        SolveIn = 1'b0; ExhaustIn = 1'b0;
        waitCycles(14);
        modelDone = 1'b1;
        tests++;
        if (seSeen != se0) begin fails++; $display("FAIL exhaust_no_shift: %0d shifts want 0", seSeen - se0); end
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL exhaust_status: got %h want %h", d, expStatus()); end
        busRead(0, d);
        tests++;
        if (d !== DW'(modelCount)) begin fails++; $display("FAIL exhaust_count: got %h want %h", d, modelCount); end
        se0 = seSeen; rs0 = rsSeen;
        doSolve();
        tests++;
        if (seSeen != se0 || rsSeen != rs0) begin
            fails++;
            $display("FAIL done_holds: shifts=%0d resumes=%0d want 0/0", seSeen - se0, rsSeen - rs0);
        end
        clearAll();
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL done_cleared: got %h want %h", d, expStatus()); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d, w;
        int k, rs0;
        clearAll();
        for (int s = 0; s < 5; s++) begin
            randomRing();
            w = ringWord();
            doSolve();
            modelSolve(w);
        end
        randomRing();
        w = ringWord();
        rs0 = rsSeen;
        @(negedge Clk);
        SolveIn = 1'b1;
        @(negedge Clk);
        SolveIn = 1'b0;
        k = 0;
        while (ScanEnable === 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        tests++;
        if (k != NR) begin fails++; $display("FAIL b2b_shift_len: got %0d want %0d", k, NR); end
        // Now in PUSH: pop lands on the same edge as the push.
        setAddr(1);
        bus.RD = 1'b1;
        #1 d = bus.DataOut;
        @(negedge Clk);
        bus.RD = 1'b0;
        waitCycles(4);
        tests++;
        if (d !== modelQ[0]) begin fails++; $display("FAIL b2b_pop: got %h want %h", d, modelQ[0]); end
        void'(modelQ.pop_front());
        modelSolve(w);
        tests++;
        if (rsSeen - rs0 != 1) begin fails++; $display("FAIL b2b_resume: got %0d want 1", rsSeen - rs0); end
        for (int i = 0; i < 5; i++) begin
            busRead(1, d);
            w = modelQ.pop_front();
            tests++;
            if (d !== w) begin fails++; $display("FAIL b2b_order%0d: got %h want %h", i, d, w); end
        end
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL b2b_occupancy: got %h want %h", d, expStatus()); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d, w;
        int rs0;
        Id = 4'hF;
        clearAll();
        for (int s = 0; s < DEP; s++) begin
            randomRing();
            w = ringWord();
            doSolve();
            modelSolve(w);
        end
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL ovf_full: got %h want %h", d, expStatus()); end
        randomRing();
        w = ringWord();
        rs0 = rsSeen;
        doSolve();
`ifdef NQUEENS_COLLECT_STALL_EN
        tests++;
        if (rsSeen != rs0) begin fails++; $display("FAIL stall_no_resume: got %0d want 0", rsSeen - rs0); end
        busRead(1, d);
        tests++;
        if (d !== modelQ[0]) begin fails++; $display("FAIL stall_pop: got %h want %h", d, modelQ[0]); end
        void'(modelQ.pop_front());
        waitCycles(4);
        modelSolve(w);
        tests++;
        if (rsSeen - rs0 != 1) begin fails++; $display("FAIL stall_resume: got %0d want 1", rsSeen - rs0); end
`else
        modelSolve(w);
        tests++;
        if (rsSeen - rs0 != 1) begin fails++; $display("FAIL ovf_resume: got %0d want 1", rsSeen - rs0); end
`endif
        busRead(2, d);
        tests++;
        if (d !== expStatus()) begin fails++; $display("FAIL ovf_status: got %h want %h", d, expStatus()); end
        busRead(0, d);
        tests++;
        if (d !== 32'd17) begin fails++; $display("FAIL ovf_count: got %h want 17", d); end
        while (modelQ.size() > 0) begin
            busRead(1, d);
            w = modelQ.pop_front();
            tests++;
            if (d !== w) begin fails++; $display("FAIL ovf_drain: got %h want %h", d, w); end
        end
        Id = 4'hA;
    endtask

    task automatic test_reset_mid_shift();
        logic [DW-1:0] d;
        int se0, rs0;
        clearAll();
        randomRing();
        doSolve();
        randomRing();
        @(negedge Clk);
        SolveIn = 1'b1;
        @(negedge Clk);
        SolveIn = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        tests++;
        if ({ScanEnable, ResumeOut, ScanOut} !== '0) begin
            fails++;
            $display("FAIL async_reset: ScanEnable=%b ResumeOut=%b ScanOut=%h, want all 0", ScanEnable, ResumeOut, ScanOut);
        end
        @(negedge Clk);
        Reset = 1'b1;
        se0 = seSeen; rs0 = rsSeen;
        waitCycles(12);
        tests++;
        if (seSeen != se0 || rsSeen != rs0) begin
            fails++;
            $display("FAIL reset_abandon: shifts=%0d resumes=%0d want 0/0", seSeen - se0, rsSeen - rs0);
        end
        busRead(0, d);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL reset_mid_count: got %h want 0", d); end
        busRead(2, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL reset_mid_status: got %h want 1", d); end
        clearAll();
        randomRing();
        d = ringWord();
        doSolve();
        modelSolve(d);
        busRead(1, d);
        tests++;
        if (d !== modelQ[0]) begin fails++; $display("FAIL after_reset_word: got %h want %h", d, modelQ[0]); end
    endtask

    initial begin
        test_reset();
        test_solution();
        test_random();
        test_exhaust_priority();
        test_back_to_back();
        test_overflow();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end
endmodule
